// File: rtl/flash_pkg.sv
// Shared types and helpers for the LED flasher tick generator.
// Holds the FSM state encoding and the divider clamp.
package flash_pkg;

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    RELOAD   = 2'd3
  } flash_state_t;

  function automatic logic [63:0] clamp_div(
    input logic [63:0] value,
    input logic [63:0] min_div
  );
    return (value < min_div) ? min_div : value;
  endfunction

endpackage

// File: rtl/ftg_counter.sv
// Period counter for the tick generator.
// Wraps to zero on the terminal count of limit-1.
module ftg_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         terminal
);

  assign terminal = enable && (cnt == limit - W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/flash_tick_gen.sv
// Clock-enable generator feeding the LED flasher stage.
// Run/pause, single-step and handshake-reloadable divider.
module flash_tick_gen
  import flash_pkg::*;
#(
  parameter int          DIV_BUS     = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic [DIV_BUS-1:0] div_in,
  input  logic               div_valid,
  output logic               div_ready,
  output logic               tick,
  output logic [DIV_BUS-1:0] cur_div,
  output logic [1:0]         state_out
);

  flash_state_t       state;
  flash_state_t       nxt;
  logic [DIV_BUS-1:0] div_lat;
  logic [DIV_BUS-1:0] cnt;
  logic               resume_run;
  logic               ready_q;
  logic               tick_q;
  logic               accept;
  logic               clear;
  logic               enable;
  logic               terminal;

  assign accept    = div_valid && ready_q;
  assign div_ready = ready_q;
  assign tick      = tick_q;
  assign state_out = state;

  ftg_counter #(
    .W(DIV_BUS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .enable  (enable),
    .limit   (cur_div),
    .cnt     (cnt),
    .terminal(terminal)
  );

  always_comb begin
    nxt    = state;
    clear  = 1'b0;
    enable = 1'b0;
    unique case (state)
      PAUSED: begin
        if (accept) begin
          nxt = RELOAD;
        end else if (run) begin
          nxt = RUNNING;
        end else if (step) begin
          nxt   = STEPPING;
          clear = 1'b1;
        end
      end
      RUNNING: begin
        if (accept) begin
          nxt = RELOAD;
        end else if (!run) begin
          nxt = PAUSED;
        end else begin
          enable = 1'b1;
        end
      end
      STEPPING: begin
        enable = 1'b1;
        if (terminal) begin
          nxt = run ? RUNNING : PAUSED;
        end
      end
      RELOAD: begin
        clear = 1'b1;
        nxt   = resume_run ? RUNNING : PAUSED;
      end
    endcase
  end

  // Ready is registered so the first cycle out of reset reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PAUSED;
      cur_div    <= DIV_BUS'(DEFAULT_DIV);
      div_lat    <= '0;
      resume_run <= 1'b0;
      tick_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state   <= nxt;
      tick_q  <= terminal;
      ready_q <= (nxt == PAUSED) || (nxt == RUNNING);
      if (accept) begin
        div_lat    <= div_in;
        resume_run <= (state == RUNNING) && run;
      end
      if (state == RELOAD) begin
        cur_div <= DIV_BUS'(clamp_div(64'(div_lat), 64'(MIN_DIV)));
      end
    end
  end

endmodule
